// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with operand forwarding and load-use stall detection (optional FORWARDING_EN)
module ex_operand_stage #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_d,
    input  logic         regwrite_d,
    input  logic         memread_d,
    input  logic         alusrc_d,
    input  logic [N-1:0] rd1_d,
    input  logic [N-1:0] rd2_d,
    input  logic [N-1:0] imm_d,
    input  logic [4:0]   ra1_d,
    input  logic [4:0]   ra2_d,
    input  logic [4:0]   rd_d,
    input  logic [3:0]   alucontrol_d,
    input  logic         flush,
    input  logic         regwrite_m,
    input  logic [4:0]   rd_m,
    input  logic [N-1:0] aluresult_m,
    input  logic         regwrite_w,
    input  logic [4:0]   rd_w,
    input  logic [N-1:0] result_w,
    output logic [N-1:0] a_e,
    output logic [N-1:0] b_e,
    output logic [N-1:0] wd_e,
    output logic [3:0]   alucontrol_e,
    output logic [4:0]   rd_e,
    output logic         valid_e,
    output logic         regwrite_e,
    output logic         memread_e,
    output logic         stall_d
);
    localparam logic [4:0] XZR = 5'd31;

    logic         alusrc_e;
    logic [N-1:0] rd1_e, rd2_e, imm_e;
    logic [4:0]   ra1_e, ra2_e;
    logic [N-1:0] fa, fb;
    logic         raw_stall;

    // EX register: bubble on stall or flush, otherwise capture the decode stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_e      <= 1'b0;
            regwrite_e   <= 1'b0;
            memread_e    <= 1'b0;
            alusrc_e     <= 1'b0;
            alucontrol_e <= '0;
            rd1_e        <= '0;
            rd2_e        <= '0;
            imm_e        <= '0;
            ra1_e        <= XZR;
            ra2_e        <= XZR;
            rd_e         <= XZR;
        end else if (flush || stall_d) begin
            valid_e      <= 1'b0;
            regwrite_e   <= 1'b0;
            memread_e    <= 1'b0;
            ra1_e        <= XZR;
            ra2_e        <= XZR;
            rd_e         <= XZR;
        end else begin
            valid_e      <= valid_d;
            regwrite_e   <= regwrite_d;
            memread_e    <= memread_d;
            alusrc_e     <= alusrc_d;
            alucontrol_e <= alucontrol_d;
            rd1_e        <= rd1_d;
            rd2_e        <= rd2_d;
            imm_e        <= imm_d;
            ra1_e        <= ra1_d;
            ra2_e        <= ra2_d;
            rd_e         <= rd_d;
        end
    end

`ifdef FORWARDING_EN
    // Bypass newest in-flight result first; register 31 is never a bypass target
    always_comb begin
        fa = (regwrite_m && rd_m == ra1_e && ra1_e != XZR) ? aluresult_m :
             (regwrite_w && rd_w == ra1_e && ra1_e != XZR) ? result_w : rd1_e;
        fb = (regwrite_m && rd_m == ra2_e && ra2_e != XZR) ? aluresult_m :
             (regwrite_w && rd_w == ra2_e && ra2_e != XZR) ? result_w : rd2_e;
    end

    // Only a load in EX feeding a used decode source must wait a cycle
    always_comb begin
        raw_stall = valid_d && valid_e && memread_e && rd_e != XZR &&
                    (rd_e == ra1_d || (rd_e == ra2_d && !alusrc_d));
    end
`else
    logic hit1, hit2;
    logic unused_fwd;

    assign unused_fwd = ^{aluresult_m, result_w, ra1_e, ra2_e};

    // No bypass: any pending writer of a used source holds decode until write-back completes
    always_comb begin
        fa   = rd1_e;
        fb   = rd2_e;
        hit1 = ra1_d != XZR && ((valid_e && regwrite_e && rd_e == ra1_d) ||
                                (regwrite_m && rd_m == ra1_d) || (regwrite_w && rd_w == ra1_d));
        hit2 = !alusrc_d && ra2_d != XZR && ((valid_e && regwrite_e && rd_e == ra2_d) ||
                                (regwrite_m && rd_m == ra2_d) || (regwrite_w && rd_w == ra2_d));
        raw_stall = valid_d && (hit1 || hit2);
    end
`endif

    assign stall_d = raw_stall && !flush;
    assign a_e     = fa;
    assign b_e     = alusrc_e ? imm_e : fb;
    assign wd_e    = fb;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed vector table plus hazard/forwarding/reset sequences for ex_operand_stage
module tb_ex_operand_stage;
    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_d, regwrite_d, memread_d, alusrc_d;
    logic [N-1:0] rd1_d, rd2_d, imm_d;
    logic [4:0]   ra1_d, ra2_d, rd_d;
    logic [3:0]   alucontrol_d;
    logic         flush;
    logic         regwrite_m, regwrite_w;
    logic [4:0]   rd_m, rd_w;
    logic [N-1:0] aluresult_m, result_w;
    logic [N-1:0] a_e, b_e, wd_e;
    logic [3:0]   alucontrol_e;
    logic [4:0]   rd_e;
    logic         valid_e, regwrite_e, memread_e, stall_d;

    int n_chk = 0;
    int n_fail = 0;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    ex_operand_stage #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .valid_d(valid_d), .regwrite_d(regwrite_d), .memread_d(memread_d), .alusrc_d(alusrc_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
        .ra1_d(ra1_d), .ra2_d(ra2_d), .rd_d(rd_d), .alucontrol_d(alucontrol_d),
        .flush(flush),
        .regwrite_m(regwrite_m), .rd_m(rd_m), .aluresult_m(aluresult_m),
        .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
        .a_e(a_e), .b_e(b_e), .wd_e(wd_e),
        .alucontrol_e(alucontrol_e), .rd_e(rd_e),
        .valid_e(valid_e), .regwrite_e(regwrite_e), .memread_e(memread_e),
        .stall_d(stall_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         valid, regwrite, memread, alusrc, flush;
        logic [N-1:0] rd1, rd2, imm;
        logic [4:0]   ra1, ra2, rd;
        logic [3:0]   alu;
        logic         x_stall, x_valid, x_regwrite, x_memread, chk_data;
        logic [N-1:0] x_a, x_b, x_wd;
        logic [4:0]   x_rd;
        logic [3:0]   x_alu;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mr, input logic as,
                         input logic [N-1:0] r1, input logic [N-1:0] r2, input logic [N-1:0] im,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                         input logic [3:0] alu);
        valid_d = v; regwrite_d = rw; memread_d = mr; alusrc_d = as;
        rd1_d = r1; rd2_d = r2; imm_d = im;
        ra1_d = a1; ra2_d = a2; rd_d = d; alucontrol_d = alu;
    endtask

    task automatic set_m(input logic rw, input logic [4:0] d, input logic [N-1:0] val);
        regwrite_m = rw; rd_m = d; aluresult_m = val;
    endtask

    task automatic set_w(input logic rw, input logic [4:0] d, input logic [N-1:0] val);
        regwrite_w = rw; rd_w = d; result_w = val;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h11, 64'h22, 64'h5, 5'd1, 5'd2, 5'd3, 4'd2,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h11, 64'h22, 64'h22, 5'd3, 4'd2};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'hAAAA, 64'h33, 64'h40, 5'd4, 5'd5, 5'd6, 4'd0,
                    1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'hAAAA, 64'h40, 64'h33, 5'd6, 4'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1, {N{1'b1}}, 64'h0, 5'd7, 5'd8, 5'd9, 4'd6,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h1, {N{1'b1}}, {N{1'b1}}, 5'd9, 4'd6};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 64'h77, 64'h0, 64'h0, 5'd10, 5'd11, 5'd12, 4'd0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 5'd31, 4'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h123, 64'h456, 64'h0, 5'd13, 5'd14, 5'd15, 4'd3,
                    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h123, 64'h456, 64'h456, 5'd15, 4'd3};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h9, 64'hA, 64'h0, 5'd15, 5'd16, 5'd17, 4'd1,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h9, 64'hA, 64'hA, 5'd17, 4'd1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 64'h5, 64'h7, 5'd31, 5'd31, 5'd31, 4'd5,
                    1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0, 64'h7, 64'h5, 5'd31, 4'd5};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h1, 5'd31, 5'd31, 5'd18, 4'd4,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h0, 5'd18, 4'd4};

        reset = 1'b1;
        flush = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 64'h5, 64'h6, 64'h7, 5'd1, 5'd2, 5'd3, 4'd1);
        set_m(1'b1, 5'd31, {N{1'b1}});
        set_w(1'b0, 5'd0, 64'h0);
        #2;
        chk("reset_a", a_e, 64'h0);
        chk("reset_b", b_e, 64'h0);
        chk("reset_wd", wd_e, 64'h0);
        chk("reset_valid", valid_e, 1'b0);
        chk("reset_stall", stall_d, 1'b0);
        repeat (2) tick();
        chk("reset_hold_a", a_e, 64'h0);
        chk("reset_hold_valid", valid_e, 1'b0);
        chk("reset_hold_rd", rd_e, 5'd31);
        reset = 1'b0;
        set_m(1'b0, 5'd0, 64'h0);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].valid, vecs[i].regwrite, vecs[i].memread, vecs[i].alusrc,
                  vecs[i].rd1, vecs[i].rd2, vecs[i].imm,
                  vecs[i].ra1, vecs[i].ra2, vecs[i].rd, vecs[i].alu);
            flush = vecs[i].flush;
            #1;
            chk($sformatf("v%0d_stall", i), stall_d, vecs[i].x_stall);
            tick();
            chk($sformatf("v%0d_valid", i), valid_e, vecs[i].x_valid);
            chk($sformatf("v%0d_regwrite", i), regwrite_e, vecs[i].x_regwrite);
            chk($sformatf("v%0d_memread", i), memread_e, vecs[i].x_memread);
            chk($sformatf("v%0d_rd", i), rd_e, vecs[i].x_rd);
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_a", i), a_e, vecs[i].x_a);
                chk($sformatf("v%0d_b", i), b_e, vecs[i].x_b);
                chk($sformatf("v%0d_wd", i), wd_e, vecs[i].x_wd);
                chk($sformatf("v%0d_alu", i), alucontrol_e, vecs[i].x_alu);
            end
        end
        flush = 1'b0;

        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h5, 64'h0, 64'h0, 5'd3, 5'd31, 5'd20, 4'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 5'd31, 5'd31, 5'd31, 4'd0);
        set_m(1'b1, 5'd3, 64'h10);
        set_w(1'b1, 5'd3, 64'h20);
        #1;
        chk("fwd_m_priority", a_e, FWD ? 64'h10 : 64'h5);
        set_m(1'b0, 5'd3, 64'h10);
        #1;
        chk("fwd_w", a_e, FWD ? 64'h20 : 64'h5);
        set_w(1'b0, 5'd0, 64'h0);

        drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h0, 64'h44, 64'h8, 5'd31, 5'd4, 5'd21, 4'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 5'd31, 5'd31, 5'd31, 4'd0);
        set_w(1'b1, 5'd4, 64'h99);
        #1;
        chk("imm_b", b_e, 64'h8);
        chk("imm_wd", wd_e, FWD ? 64'h99 : 64'h44);
        set_w(1'b0, 5'd0, 64'h0);

        drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h0, 64'h0, 64'h0, 5'd31, 5'd31, 5'd9, 4'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h55, 64'h0, 64'h0, 5'd9, 5'd31, 5'd22, 4'd0);
        #1;
        chk("lu_stall", stall_d, 1'b1);
        tick();
        chk("lu_bubble_valid", valid_e, 1'b0);
        chk("lu_bubble_rd", rd_e, 5'd31);
        set_m(1'b1, 5'd9, 64'h77);
        #1;
        chk("lu_stall_after", stall_d, FWD ? 1'b0 : 1'b1);
        tick();
`ifdef FORWARDING_EN
        chk("lu_load_valid", valid_e, 1'b1);
        chk("lu_load_rd", rd_e, 5'd22);
        chk("lu_load_a", a_e, 64'h77);
`else
        chk("lu_bubble2_valid", valid_e, 1'b0);
        set_m(1'b0, 5'd0, 64'h0);
        #1;
        chk("lu_release", stall_d, 1'b0);
        tick();
        chk("lu_load_valid", valid_e, 1'b1);
        chk("lu_load_rd", rd_e, 5'd22);
        chk("lu_load_a", a_e, 64'h55);
`endif
        set_m(1'b0, 5'd0, 64'h0);

        drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h0, 64'h0, 64'h0, 5'd31, 5'd31, 5'd9, 4'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h55, 64'h0, 64'h0, 5'd9, 5'd31, 5'd22, 4'd0);
        flush = 1'b1;
        #1;
        chk("flush_stall", stall_d, 1'b0);
        tick();
        chk("flush_valid", valid_e, 1'b0);
        chk("flush_regwrite", regwrite_e, 1'b0);
        flush = 1'b0;

        drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h0, 64'h0, 64'h0, 5'd31, 5'd31, 5'd9, 4'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h66, 64'h0, 64'h0, 5'd9, 5'd31, 5'd24, 4'd0);
        #1;
        chk("rst_stall_pre", stall_d, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_async_valid", valid_e, 1'b0);
        chk("rst_async_stall", stall_d, 1'b0);
        #2;
        reset = 1'b0;
        tick();
        chk("rst_post_valid", valid_e, 1'b1);
        chk("rst_post_rd", rd_e, 5'd24);
        chk("rst_post_a", a_e, 64'h66);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 5'd31, 5'd31, 5'd25, 4'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 5'd31, 5'd31, 5'd31, 4'd0);
        set_m(1'b1, 5'd31, 64'hDEAD);
        set_w(1'b1, 5'd31, 64'hBEEF);
        #1;
        chk("xzr_a", a_e, 64'h0);
        chk("xzr_b", b_e, 64'h0);
        set_m(1'b0, 5'd0, 64'h0);
        set_w(1'b0, 5'd0, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
